clock_time_counter: RTL and testbench

Timekeeping stage feeding `seg7_control`. Divides the 100 MHz board clock to a 1 Hz tick and keeps a 12-hour time of day (hours, minutes, seconds, AM/PM). Takes two raw push-buttons for setting the time, synchronised and debounced internally. Drives the BCD digit buses that the display multiplexer consumes.

---
 rtl/clock_time_counter.sv | 170 +++++++++++++++++
 tb/tb_clock_time_counter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_counter.sv
// clock_time_counter: 12-hour time-of-day keeper for the seg7 display path.
// Divides the board clock to a 1 Hz tick and advances hh:mm:ss AM/PM.
// Two raw push-buttons (hours, minutes) are synchronised and debounced here,
// and each accepted press sets the time.
module clock_time_counter #(
    parameter int TICK_CYCLES     = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk_100Mhz,
    input  logic       reset,
    input  logic       btn_hrs,
    input  logic       btn_mins,
    output logic [2:0] hrs_tens,
    output logic [3:0] hrs_ones,
    output logic [2:0] mins_tens,
    output logic [3:0] mins_ones,
    output logic [5:0] secs,
    output logic       pm
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

    // Button index 0 is hours, index 1 is minutes.
    logic [1:0]    btn_raw;
    logic [1:0]    sync_a;
    logic [1:0]    sync_b;
    logic [1:0]    accepted;
    logic [1:0]    accepted_d;
    logic [1:0]    press;
    logic [DW-1:0] db_cnt [2];

    logic [PW-1:0] presc;
    logic          tick;
    logic          inc_hrs;
    logic          inc_mins;

    logic [2:0]    hrs_tens_n;
    logic [3:0]    hrs_ones_n;
    logic [2:0]    mins_tens_n;
    logic [3:0]    mins_ones_n;
    logic [5:0]    secs_n;
    logic          pm_n;
    logic          hrs_step;
    logic          mins_step;

    assign btn_raw  = {btn_mins, btn_hrs};
    assign press    = accepted & ~accepted_d;
    assign inc_hrs  = press[0];
    assign inc_mins = press[1];
    assign tick     = (presc == PRESC_LAST);

    // Prescaler: wraps every TICK_CYCLES clocks; a minute set restarts the second.
    always_ff @(posedge clk_100Mhz or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (inc_mins || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Per-button 2-flop synchroniser, debouncer and rising-edge history.
    always_ff @(posedge clk_100Mhz or posedge reset) begin
        if (reset) begin
            sync_a     <= '0;
            sync_b     <= '0;
            accepted   <= '0;
            accepted_d <= '0;
            db_cnt[0]  <= '0;
            db_cnt[1]  <= '0;
        end else begin
            sync_a     <= btn_raw;
            sync_b     <= sync_a;
            accepted_d <= accepted;
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] != accepted[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        accepted[i] <= sync_b[i];
                        db_cnt[i]   <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Next time value: a press outranks the tick in the same cycle, and a
    // minute set never carries into hours.
    always_comb begin
        hrs_tens_n  = hrs_tens;
        hrs_ones_n  = hrs_ones;
        mins_tens_n = mins_tens;
        mins_ones_n = mins_ones;
        secs_n      = secs;
        pm_n        = pm;
        hrs_step    = 1'b0;
        mins_step   = 1'b0;

        if (inc_hrs || inc_mins) begin
            if (inc_mins) begin
                mins_step = 1'b1;
                secs_n    = '0;
            end
            if (inc_hrs) begin
                hrs_step = 1'b1;
            end
        end else if (tick) begin
            if (secs == 6'd59) begin
                secs_n    = '0;
                mins_step = 1'b1;
                if (mins_tens == 3'd5 && mins_ones == 4'd9) begin
                    hrs_step = 1'b1;
                end
            end else begin
                secs_n = secs + 6'd1;
            end
        end

        if (mins_step) begin
            if (mins_ones == 4'd9) begin
                mins_ones_n = 4'd0;
                mins_tens_n = (mins_tens == 3'd5) ? 3'd0 : mins_tens + 3'd1;
            end else begin
                mins_ones_n = mins_ones + 4'd1;
            end
        end

        if (hrs_step) begin
            if (hrs_tens == 3'd1 && hrs_ones == 4'd2) begin
                hrs_tens_n = 3'd0;
                hrs_ones_n = 4'd1;
            end else if (hrs_tens == 3'd0 && hrs_ones == 4'd9) begin
                hrs_tens_n = 3'd1;
                hrs_ones_n = 4'd0;
            end else begin
                hrs_ones_n = hrs_ones + 4'd1;
            end
            if (hrs_tens == 3'd1 && hrs_ones == 4'd1) begin
                pm_n = ~pm;
            end
        end
    end

    // Time registers; reset shows 12:00:00 AM.
    always_ff @(posedge clk_100Mhz or posedge reset) begin
        if (reset) begin
            hrs_tens  <= 3'd1;
            hrs_ones  <= 4'd2;
            mins_tens <= 3'd0;
            mins_ones <= 4'd0;
            secs      <= 6'd0;
            pm        <= 1'b0;
        end else begin
            hrs_tens  <= hrs_tens_n;
            hrs_ones  <= hrs_ones_n;
            mins_tens <= mins_tens_n;
            mins_ones <= mins_ones_n;
            secs      <= secs_n;
            pm        <= pm_n;
        end
    end

endmodule

// File: tb/tb_clock_time_counter.sv
// tb_clock_time_counter: directed bench for clock_time_counter with a short
// tick (10 clocks) and debounce window (4 clocks). Expected values are hand
// computed from the cycle position of each step.
module tb_clock_time_counter;

    logic       clk_100Mhz;
    logic       reset;
    logic       btn_hrs;
    logic       btn_mins;
    logic [2:0] hrs_tens;
    logic [3:0] hrs_ones;
    logic [2:0] mins_tens;
    logic [3:0] mins_ones;
    logic [5:0] secs;
    logic       pm;

    int total;
    int bad;

    clock_time_counter #(
        .TICK_CYCLES    (10),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk_100Mhz(clk_100Mhz),
        .reset     (reset),
        .btn_hrs   (btn_hrs),
        .btn_mins  (btn_mins),
        .hrs_tens  (hrs_tens),
        .hrs_ones  (hrs_ones),
        .mins_tens (mins_tens),
        .mins_ones (mins_ones),
        .secs      (secs),
        .pm        (pm)
    );

    initial clk_100Mhz = 1'b0;
    always #5 clk_100Mhz = ~clk_100Mhz;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_hm(input string tag, input int ht, input int ho, input int mt, input int mo);
        check({tag, ".hrs_tens"},  int'(hrs_tens),  ht);
        check({tag, ".hrs_ones"},  int'(hrs_ones),  ho);
        check({tag, ".mins_tens"}, int'(mins_tens), mt);
        check({tag, ".mins_ones"}, int'(mins_ones), mo);
    endtask

    // From a negedge: n rising edges, then land on the following negedge.
    task automatic edges(input int n);
        repeat (n) @(posedge clk_100Mhz);
        @(negedge clk_100Mhz);
    endtask

    // Raise the chosen buttons; returns just after the update edge (edge 7).
    task automatic press(input logic h, input logic m);
        btn_hrs  = h;
        btn_mins = m;
        edges(7);
    endtask

    // Drop both buttons and let the release debounce settle (no pulse).
    task automatic release_btns();
        btn_hrs  = 1'b0;
        btn_mins = 1'b0;
        edges(8);
    endtask

    task automatic press_n(input logic h, input logic m, input int n);
        for (int k = 0; k < n; k++) begin
            press(h, m);
            release_btns();
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        btn_hrs  = 1'b0;
        btn_mins = 1'b0;
        repeat (3) @(negedge clk_100Mhz);
        reset = 1'b0;

        // Reset values and first tick
        check_hm("rst", 1, 2, 0, 0);
        check("rst.secs", int'(secs), 0);
        check("rst.pm", int'(pm), 0);
        edges(9);
        check("pre_tick.secs", int'(secs), 0);
        edges(1);
        check("first_tick.secs", int'(secs), 1);
        edges(590);
        check_hm("t600", 1, 2, 0, 1);
        check("t600.secs", int'(secs), 0);

        // Preload 12:59:59 then roll to 01:00:00
        press_n(1'b0, 1'b1, 58);
        check_hm("set_12_59", 1, 2, 5, 9);
        check("set_12_59.secs", int'(secs), 0);
        edges(582);
        check("t12_59_59.secs", int'(secs), 59);
        edges(1);
        check_hm("mid_tick", 1, 2, 5, 9);
        edges(9);
        check_hm("roll_01", 0, 1, 0, 0);
        check("roll_01.secs", int'(secs), 0);
        check("roll_01.pm", int'(pm), 0);

        // 09:59:59 -> 10:00:00
        press_n(1'b1, 1'b0, 8);
        check_hm("set_09", 0, 9, 0, 0);
        press_n(1'b0, 1'b1, 59);
        edges(582);
        check_hm("t09_59_59", 0, 9, 5, 9);
        check("t09_59_59.secs", int'(secs), 59);
        edges(10);
        check_hm("roll_10", 1, 0, 0, 0);
        check("roll_10.secs", int'(secs), 0);
        check("roll_10.pm", int'(pm), 0);

        // 11:59:59 AM -> 12:00:00 PM, then 12 hour presses back to AM
        press_n(1'b1, 1'b0, 1);
        press_n(1'b0, 1'b1, 59);
        edges(582);
        check_hm("t11_59_59", 1, 1, 5, 9);
        check("t11_59_59.pm", int'(pm), 0);
        edges(10);
        check_hm("roll_12pm", 1, 2, 0, 0);
        check("roll_12pm.secs", int'(secs), 0);
        check("roll_12pm.pm", int'(pm), 1);
        press_n(1'b1, 1'b0, 1);
        check_hm("hrs_press_01", 0, 1, 0, 0);
        check("hrs_press_01.pm", int'(pm), 1);
        press_n(1'b1, 1'b0, 11);
        check_hm("hrs_press_12", 1, 2, 0, 0);
        check("hrs_press_12.pm", int'(pm), 0);

        // Bounce rejection then a held press
        for (int k = 0; k < 5; k++) begin
            btn_mins = 1'b1;
            edges(2);
            btn_mins = 1'b0;
            edges(2);
        end
        btn_mins = 1'b1;
        edges(6);
        check("bounce_e6.mins_ones", int'(mins_ones), 0);
        edges(1);
        check("bounce_e7.mins_ones", int'(mins_ones), 1);
        check("bounce_e7.secs", int'(secs), 0);
        edges(9);
        check("presc_clr_9.secs", int'(secs), 0);
        edges(1);
        check("presc_clr_10.secs", int'(secs), 1);
        edges(20);
        check("no_repeat.mins_ones", int'(mins_ones), 1);
        release_btns();

        // Minute set wrap without hour carry
        press_n(1'b0, 1'b1, 58);
        check_hm("set_59", 1, 2, 5, 9);
        press(1'b0, 1'b1);
        check_hm("min_wrap", 1, 2, 0, 0);
        check("min_wrap.pm", int'(pm), 0);
        release_btns();

        // Coincident hour and minute presses
        press(1'b1, 1'b1);
        check_hm("both", 0, 1, 0, 1);
        check("both.secs", int'(secs), 0);
        check("both.pm", int'(pm), 0);
        release_btns();

        // Hour press aligned with a tick: tick is dropped
        edges(5);
        check("pre_align.secs", int'(secs), 1);
        press(1'b1, 1'b0);
        check_hm("align", 0, 2, 0, 1);
        check("align.secs", int'(secs), 1);
        release_btns();
        edges(1);
        check("after_align_9.secs", int'(secs), 1);
        edges(1);
        check("after_align_10.secs", int'(secs), 2);

        // Asynchronous reset between edges
        #2;
        reset = 1'b1;
        #1;
        check_hm("async_rst", 1, 2, 0, 0);
        check("async_rst.secs", int'(secs), 0);
        check("async_rst.pm", int'(pm), 0);
        @(negedge clk_100Mhz);
        reset = 1'b0;
        edges(10);
        check("post_rst_tick.secs", int'(secs), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
